// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM sequential multiplier: controller state
// encoding and the enum type used by the FSM.
package drum_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PREP = 2'd1;
   localparam logic [1:0] ST_MULT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      PREP = ST_PREP,
      MULT = ST_MULT,
      DONE = ST_DONE
   } drumStateT;

endpackage

// File: rtl/drum_lod_truncate.sv
// Combinational DRUM operand reduction: finds the leading one of x and keeps
// the K bits starting there, with the lowest kept bit forced to 1 so the
// dropped tail is replaced by its expected midpoint. Small operands (including
// zero) pass through untouched with no shift.
module drum_lod_truncate #(
   parameter int N = 16,
   parameter int K = 6
) (
   input  logic [N-1:0]         x,
   output logic [K-1:0]         tx,
   output logic [$clog2(N)-1:0] sx
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] lead;

   // Leading-one detector: the highest set bit wins because later loop
   // iterations overwrite earlier ones.
   always_comb begin
      lead = '0;
      for (int i = 0; i < N; i++) begin
         if (x[i]) begin
            lead = SW'(i);
         end
      end
   end

   // Truncation: only operands with a set bit at or above position K are
   // reduced; the shift amount is how far the K-bit window sits above bit 0.
   always_comb begin
      tx = x[K-1:0];
      sx = '0;
      if ((x >> K) != '0) begin
         sx = lead - SW'(K - 1);
         tx = K'(x >> sx) | K'(1);
      end
   end

endmodule

// File: rtl/drum_seq_multiplier.sv
// Sequential shift-add unsigned multiplier with an optional DRUM approximate
// mode. Operands are accepted in IDLE, reduced in PREP, multiplied one bit
// per cycle in MULT, and the product is held in DONE until taken.
module drum_seq_multiplier
   import drum_pkg::*;
#(
   parameter int N = 16,
   parameter int K = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           approx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int PW  = 2 * N;
   localparam int SW  = $clog2(N);
   localparam int SHW = SW + 1;
   localparam int CW  = $clog2(N + 1);

   drumStateT state;
   drumStateT nextState;

   logic [N-1:0]   aReg;
   logic [N-1:0]   bReg;
   logic           approxReg;
   logic [PW-1:0]  mcand;
   logic [N-1:0]   mplier;
   logic [PW-1:0]  acc;
   logic [SHW-1:0] shiftReg;
   logic [CW-1:0]  stepCnt;
   logic [CW-1:0]  stepLimit;
   logic [K-1:0]   taA;
   logic [K-1:0]   taB;
   logic [SW-1:0]  saA;
   logic [SW-1:0]  saB;

   drum_lod_truncate #(.N(N), .K(K)) u_truncA (
      .x  (aReg),
      .tx (taA),
      .sx (saA)
   );

   drum_lod_truncate #(.N(N), .K(K)) u_truncB (
      .x  (bReg),
      .tx (taB),
      .sx (saB)
   );

   assign stepLimit = approxReg ? CW'(K) : CW'(N);

   // State register; reset aborts whatever operation is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake outputs. MULT lingers one extra cycle after the
   // last step so the final scaling shift lands in the product register as
   // DONE is entered.
   always_comb begin
      nextState = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               nextState = PREP;
            end
         end
         PREP: begin
            nextState = MULT;
         end
         MULT: begin
            if (stepCnt == stepLimit) begin
               nextState = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, working-operand setup, one shift-add step per
   // MULT cycle, then the scaled result is written to the product register,
   // which is otherwise left alone so it keeps the last delivered value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aReg      <= '0;
         bReg      <= '0;
         approxReg <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         shiftReg  <= '0;
         stepCnt   <= '0;
         product   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  aReg      <= a;
                  bReg      <= b;
                  approxReg <= approx;
               end
            end
            PREP: begin
               acc     <= '0;
               stepCnt <= '0;
               if (approxReg) begin
                  mcand    <= PW'(taA);
                  mplier   <= N'(taB);
                  shiftReg <= SHW'(saA) + SHW'(saB);
               end else begin
                  mcand    <= PW'(aReg);
                  mplier   <= bReg;
                  shiftReg <= '0;
               end
            end
            MULT: begin
               if (stepCnt == stepLimit) begin
                  product <= acc << shiftReg;
               end else begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand   <= mcand << 1;
                  mplier  <= mplier >> 1;
                  stepCnt <= stepCnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
